// File: rtl/lmc_mem_ctrl.sv
// LMC main memory with boot sequencer: a hardware clear sweep, then a streamed
// program load, then a terminal RUN phase serving the CPU with range checking.
module lmc_mem_ctrl #(
    parameter int DEPTH   = 100,
    parameter int DATA_W  = 11,
    parameter int ADDR_W  = 7,
    parameter int MAX_VAL = 999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_skip,
    output logic              load_ready,
    output logic [ADDR_W-1:0] load_count,
    output logic              load_err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // DEPTH is compared one bit wider so that DEPTH == 2**ADDR_W still works.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] MAX_WORD  = DATA_W'(MAX_VAL);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              load_err_q, load_err_d;
    logic              cpu_err_q, cpu_err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic cpu_addr_ok;
    logic cpu_data_ok;
    logic load_data_ok;

    assign cpu_addr_ok  = ({1'b0, cpu_addr} < DEPTH_X);
    assign cpu_data_ok  = (cpu_wdata <= MAX_WORD);
    assign load_data_ok = (load_data <= MAX_WORD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            addr_q     <= '0;
            count_q    <= '0;
            load_err_q <= 1'b0;
            cpu_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            load_err_q <= load_err_d;
            cpu_err_q  <= cpu_err_d;
        end
    end

    // Single write port shared by the sweep, the loader and the CPU.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        load_err_d = load_err_q;
        cpu_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            ST_LOAD: begin
                if (load_valid) begin
                    mem_we = 1'b1;
                    if (load_data_ok) begin
                        mem_wdata = load_data;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    if ({1'b0, count_q} < DEPTH_X) begin
                        count_d = count_q + 1'b1;
                    end
                    if (load_last || (addr_q == LAST_ADDR)) begin
                        state_d = ST_RUN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (load_skip) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (cpu_we) begin
                    if (cpu_addr_ok && cpu_data_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end else begin
                        cpu_err_d = 1'b1;
                    end
                end else if (!cpu_addr_ok) begin
                    cpu_err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                addr_d  = '0;
            end
        endcase
    end

    // Array is deliberately left out of reset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign cpu_rdata  = ((state_q == ST_RUN) && cpu_addr_ok) ? mem[cpu_addr] : '0;
    assign cpu_ready  = (state_q == ST_RUN);
    assign cpu_err    = cpu_err_q;
    assign load_ready = (state_q == ST_LOAD);
    assign load_count = count_q;
    assign load_err   = load_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lmc_mem_ctrl.sv
// Directed bench for lmc_mem_ctrl: stimulus pushes hand-computed expectations
// into a scoreboard queue that a negedge monitor drains and compares.
module tb_lmc_mem_ctrl;

    localparam int DEPTH  = 100;
    localparam int DATA_W = 11;
    localparam int ADDR_W = 7;

    localparam int K_STATE = 0;
    localparam int K_RDATA = 1;
    localparam int K_COUNT = 2;
    localparam int K_LERR  = 3;
    localparam int K_CERR  = 4;
    localparam int K_LRDY  = 5;
    localparam int K_CRDY  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_we = 1'b0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_skip = 1'b0;
    logic              load_ready;
    logic [ADDR_W-1:0] load_count;
    logic              load_err;
    logic [1:0]        state;

    always #5 clk = ~clk;

    lmc_mem_ctrl #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAX_VAL(999)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_skip (load_skip),
        .load_ready(load_ready),
        .load_count(load_count),
        .load_err  (load_err),
        .state     (state)
    );

    int    vectors = 0;
    int    miscompares = 0;
    string q_name[$];
    int    q_kind[$];
    int    q_exp[$];

    // Monitor: samples the DUT away from the active edge and scores every queued expectation.
    always @(negedge clk) begin : monitor
        string nm;
        int    k;
        int    e;
        int    act;
        while (q_name.size() > 0) begin
            nm = q_name.pop_front();
            k  = q_kind.pop_front();
            e  = q_exp.pop_front();
            case (k)
                K_STATE: act = int'(state);
                K_RDATA: act = int'(cpu_rdata);
                K_COUNT: act = int'(load_count);
                K_LERR:  act = int'(load_err);
                K_CERR:  act = int'(cpu_err);
                K_LRDY:  act = int'(load_ready);
                default: act = int'(cpu_ready);
            endcase
            vectors++;
            if (act != e) begin
                miscompares++;
                $display("FAIL %s: got %0d, expected %0d", nm, act, e);
            end
        end
    end

    task automatic chk(input string nm, input int kind, input int expv);
        q_name.push_back(nm);
        q_kind.push_back(kind);
        q_exp.push_back(expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_we     = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_skip  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_clear();
        repeat (DEPTH) tick();
        chk("clear_done_state", K_STATE, 1);
    endtask

    task automatic load_word(input int data, input bit last);
        load_valid = 1'b1;
        load_data  = DATA_W'(data);
        load_last  = last;
        $display("load  data=%0d last=%0d", data, last);
        tick();
        idle();
    endtask

    task automatic cpu_read(input int addr, input int expv);
        cpu_we   = 1'b0;
        cpu_addr = ADDR_W'(addr);
        chk($sformatf("read_%0d", addr), K_RDATA, expv);
        $display("read  addr=%0d expect=%0d", addr, expv);
        tick();
    endtask

    int bp_val[6] = '{11, 22, 33, 55, 1000, 66};
    bit bp_v[6]   = '{1, 0, 1, 0, 1, 1};
    int bp_cnt[6] = '{1, 1, 2, 2, 3, 4};
    int bp_err[6] = '{0, 0, 0, 0, 1, 1};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset values, sampled while reset is held.
        reset = 1'b1;
        tick();
        chk("rst_state", K_STATE, 0);
        chk("rst_load_ready", K_LRDY, 0);
        chk("rst_cpu_ready", K_CRDY, 0);
        chk("rst_count", K_COUNT, 0);
        chk("rst_load_err", K_LERR, 0);
        chk("rst_cpu_err", K_CERR, 0);
        chk("rst_rdata", K_RDATA, 0);
        tick();
        reset = 1'b0;

        // Clear sweep lasts exactly DEPTH cycles.
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("clear_state_c%0d", i), K_STATE, 0);
            tick();
        end
        chk("load_state", K_STATE, 1);
        chk("load_ready_hi", K_LRDY, 1);

        // Program load 521,120,321,520 then RUN.
        load_word(521, 1'b0);
        chk("cnt_after_1", K_COUNT, 1);
        load_word(120, 1'b0);
        chk("cnt_after_2", K_COUNT, 2);
        load_word(321, 1'b0);
        chk("state_before_last", K_STATE, 1);
        load_word(520, 1'b1);
        chk("run_state", K_STATE, 2);
        chk("run_count", K_COUNT, 4);
        chk("run_cpu_ready", K_CRDY, 1);
        chk("run_load_ready", K_LRDY, 0);
        chk("run_load_err", K_LERR, 0);
        cpu_read(0, 521);
        cpu_read(1, 120);
        cpu_read(2, 321);
        cpu_read(3, 520);
        cpu_read(4, 0);
        chk("read_ok_no_err", K_CERR, 0);

        // Out-of-range data write.
        cpu_we = 1'b1; cpu_addr = 5; cpu_wdata = 1000;
        $display("write addr=5 data=1000");
        tick();
        cpu_we = 1'b0;
        chk("bad_data_err", K_CERR, 1);
        chk("bad_data_mem5", K_RDATA, 0);
        tick();
        chk("bad_data_err_end", K_CERR, 0);

        // Out-of-range address write.
        cpu_we = 1'b1; cpu_addr = 100; cpu_wdata = 7;
        $display("write addr=100 data=7");
        tick();
        cpu_we = 1'b0; cpu_addr = 3;
        chk("bad_addr_err", K_CERR, 1);
        chk("bad_addr_mem3", K_RDATA, 520);
        tick();
        chk("bad_addr_err_end", K_CERR, 0);

        // Out-of-range read.
        cpu_addr = 120;
        $display("read  addr=120");
        chk("read120_data", K_RDATA, 0);
        chk("read120_err_not_yet", K_CERR, 0);
        tick();
        cpu_addr = 0;
        chk("read120_err", K_CERR, 1);
        tick();
        chk("read120_err_end", K_CERR, 0);

        // Legal write becomes visible the next cycle.
        cpu_we = 1'b1; cpu_addr = 5; cpu_wdata = 999;
        $display("write addr=5 data=999");
        chk("wr5_old_value", K_RDATA, 0);
        tick();
        cpu_we = 1'b0;
        chk("wr5_new_value", K_RDATA, 999);
        chk("wr5_no_err", K_CERR, 0);
        tick();

        // Load port ignored in RUN.
        load_valid = 1'b1; load_data = 77; load_last = 1'b1;
        tick();
        idle();
        chk("run_ignores_load_cnt", K_COUNT, 4);
        cpu_read(4, 0);

        // Backpressure, out-of-range load word, then skip.
        do_reset();
        wait_clear();
        for (int i = 0; i < 6; i++) begin
            load_valid = bp_v[i];
            load_data  = DATA_W'(bp_val[i]);
            $display("load  data=%0d valid=%0d", bp_val[i], bp_v[i]);
            tick();
            chk($sformatf("bp_count_%0d", i), K_COUNT, bp_cnt[i]);
            chk($sformatf("bp_err_%0d", i), K_LERR, bp_err[i]);
        end
        idle();
        chk("bp_still_load", K_STATE, 1);
        load_skip = 1'b1;
        $display("skip");
        tick();
        idle();
        chk("skip_state", K_STATE, 2);
        chk("skip_count", K_COUNT, 4);
        chk("skip_err_sticky", K_LERR, 1);
        cpu_read(0, 11);
        cpu_read(1, 33);
        cpu_read(2, 0);
        cpu_read(3, 66);
        cpu_read(4, 0);

        // Reset in the middle of a load.
        do_reset();
        chk("reset_clears_err", K_LERR, 0);
        wait_clear();
        load_word(700, 1'b0);
        load_word(701, 1'b0);
        chk("midload_count", K_COUNT, 2);
        tick();
        reset = 1'b1;
        $display("async reset mid-load");
        chk("midrst_state", K_STATE, 0);
        chk("midrst_count", K_COUNT, 0);
        chk("midrst_load_ready", K_LRDY, 0);
        tick();
        tick();
        reset = 1'b0;
        wait_clear();
        load_skip = 1'b1;
        tick();
        idle();
        chk("reload_skip_state", K_STATE, 2);
        chk("reload_skip_count", K_COUNT, 0);
        cpu_read(0, 0);
        cpu_read(1, 0);
        cpu_read(50, 0);

        // Full-depth load without load_last.
        do_reset();
        wait_clear();
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = DATA_W'(i * 9);
            if (i == DEPTH - 1) begin
                chk("full_state_before_last", K_STATE, 1);
                chk("full_count_before_last", K_COUNT, 99);
            end
            tick();
        end
        idle();
        $display("load  %0d words streamed", DEPTH);
        chk("full_state", K_STATE, 2);
        chk("full_count", K_COUNT, 100);
        cpu_read(99, 891);
        cpu_read(0, 0);
        cpu_read(50, 450);

        // Inputs ignored during clear; skip coinciding with a handshake.
        do_reset();
        cpu_we = 1'b1; cpu_addr = 60; cpu_wdata = 5;
        load_valid = 1'b1; load_data = 77;
        repeat (DEPTH - 1) tick();
        chk("clear_cpu_err", K_CERR, 0);
        chk("clear_rdata", K_RDATA, 0);
        chk("clear_count", K_COUNT, 0);
        idle();
        tick();
        chk("clear2_state", K_STATE, 1);
        load_valid = 1'b1; load_data = 123; load_skip = 1'b1;
        $display("load  data=123 with skip");
        tick();
        idle();
        chk("skiphs_state", K_STATE, 2);
        chk("skiphs_count", K_COUNT, 1);
        cpu_read(0, 123);
        cpu_read(1, 0);
        cpu_read(60, 0);

        tick();
        if (q_name.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_name.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lmc_mem_ctrl.md
Name: lmc_mem_ctrl

Overview:
- Parametrised LMC main memory with a built-in boot sequencer. It replaces the hard-wired program preload with three phases:
  - a hardware clear sweep;
  - a streamed program-load port with a valid/ready handshake;
  - a RUN phase that serves the CPU.
- It sits between the LMC datapath (CPU port) and the board-level program loader (load port).
- It adds range checking on addresses and on the decimal word value.

Parameters:
- DEPTH, 100, number of words.
- DATA_W, 11, word width in bits.
- ADDR_W, 7, address width. Must satisfy 2**ADDR_W >= DEPTH.
- MAX_VAL, 999, largest legal stored value (3 decimal digits).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_rdata  out  DATA_W  CPU read data (combinational).
- cpu_ready  out  1  high only in RUN.
- cpu_err  out  1  one-cycle pulse on an illegal CPU access.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  load word.
- load_last  in  1  marks the final word of the program.
- load_skip  in  1  leave LOAD without writing a word.
- load_ready  out  1  high only in LOAD.
- load_count  out  ADDR_W  number of words accepted in the current load.
- load_err  out  1  sticky flag: an out-of-range load word was seen.
- state  out  2  current phase: CLEAR=0, LOAD=1, RUN=2.

Behaviour:
- **Reset:**
  - state=CLEAR, sweep/load address=0, load_count=0, load_err=0, cpu_err=0.
  - cpu_ready=0, load_ready=0, cpu_rdata=0.
  - The array itself is not reset, to allow RAM inference.
- **CLEAR:**
  - Writes 0 to address a each cycle, for a = 0 .. DEPTH-1.
  - Takes exactly DEPTH cycles after reset deasserts. The cycle after the write to DEPTH-1, state=LOAD.
  - All CPU and load inputs are ignored.
- **LOAD:**
  - load_ready=1. A handshake is load_valid & load_ready.
  - Each handshake writes load_data to the current load address, then increments the address and load_count.
  - If load_data > MAX_VAL, 0 is written instead and load_err is set. load_err stays set until reset.
  - Transition to RUN on the next edge when any of the following holds:
    - a handshake with load_last=1 (that word is written);
    - the handshake that writes address DEPTH-1;
    - load_skip=1.
  - If load_skip and a handshake occur in the same cycle, the word is written and the transition still happens.
  - load_count saturates at DEPTH.
- **RUN (terminal until reset):**
  - cpu_ready=1, load_ready=0. Load inputs are ignored.
  - Read: cpu_rdata = mem[cpu_addr] combinationally when cpu_addr < DEPTH; otherwise 0.
  - Write: on the clock edge when cpu_we=1, cpu_addr < DEPTH and cpu_wdata <= MAX_VAL. A write is visible to a read at the same address on the next cycle.
  - If cpu_we=1 and either cpu_addr >= DEPTH or cpu_wdata > MAX_VAL:
    - no write occurs;
    - cpu_err=1 for exactly the following cycle.
  - A read at cpu_addr >= DEPTH (cpu_we=0) also pulses cpu_err the following cycle.
- **Outside RUN:** cpu_rdata=0, cpu_err stays 0, and cpu_we has no effect.
- **Reset mid-operation:** asynchronous return to CLEAR with address=0. Memory contents are undefined until the sweep completes; no partial load survives.
- **Widths:** all comparisons are unsigned. load_count is ADDR_W bits and cannot exceed DEPTH.

Test Plan:
- **Clear timing:** release reset, idle inputs -> state=0 for exactly 100 cycles, then state=1 and load_ready=1. A subsequent skip followed by reading any address gives 0.
- **Program load and run:**
  - stimulus: stream 521,120,321,520 with load_last on 520;
  - -> load_count=4, state=2 one cycle after the last handshake;
  - -> cpu_addr=0..3 read 521,120,321,520; cpu_addr=4 reads 0.
- **Backpressure and skip:**
  - stimulus: load_valid toggled with gaps, then load_skip alone;
  - -> only cycles with valid high advance load_count;
  - -> skip writes nothing and state=2.
- **Full-depth load:** stream 100 words without load_last -> automatic RUN after the word at address 99; mem[99] holds the 100th word; load_count=100.
- **Range errors:**
  - load word 1000 -> address stores 0, load_err=1 (sticky);
  - in RUN, write 1000 to addr 5 -> mem[5] unchanged, cpu_err pulses once;
  - in RUN, write to addr 100 -> ignored, cpu_err pulses once; read of addr 120 -> 0 plus a cpu_err pulse.
- **Reset mid-load:** assert reset after 2 load handshakes -> state=0 immediately and load_count=0; after re-clear, the previously loaded addresses read 0.
